// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// ----------------
// Control FSM for the multicycle ARM datapath (16x32 register file, shared
// ALU, unified memory). Sequences fetch / decode / execute / memory /
// writeback, drives the datapath mux selects and write strobes, and holds
// the NZCV flag register used to evaluate ARM condition codes.
//
// Optional feature macro: MULTICYCLE_CTRL_BL_EN
//   When defined, adds output linkwrite and performs the BL link write
//   (regwrite + linkwrite) in the BRANCH state when funct[4] is set.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   cond       instr[31:28] condition field
//   op         instr[27:26] instruction class
//   funct      instr[25:20] {I, cmd[3:0], S}
//   rd         instr[15:12] destination register (not used by this FSM)
//   aluflags   NZCV produced by the ALU in the current cycle
//   irwrite    instruction register load
//   pcwrite    PC load
//   regwrite   register-file write enable (we3)
//   memwrite   memory write strobe
//   adrsrc     memory address select: 0 = PC, 1 = ALU result register
//   alusrca    ALU A select: 00 = rd1, 01 = PC
//   alusrcb    ALU B select: 00 = rd2, 01 = imm, 10 = const 4
//   resultsrc  result select: 00 = ALUOut, 01 = Data, 10 = ALU direct
//   alucontrol ALU op: 00 add, 01 sub, 10 and, 11 orr
//   immsrc     immediate extend select (equals op)
//   regsrc     register read address selects
//   state_o    current FSM state (debug)
//   linkwrite  BL link write marker (only with MULTICYCLE_CTRL_BL_EN)

module multicycle_ctrl #(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] aluflags,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       adrsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic [1:0] alucontrol,
    output logic [1:0] immsrc,
    output logic [1:0] regsrc,
    output logic [3:0] state_o
`ifdef MULTICYCLE_CTRL_BL_EN
    ,
    output logic       linkwrite
`endif
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXECR  = 4'd6;
    localparam logic [3:0] EXECI  = 4'd7;
    localparam logic [3:0] ALUWB  = 4'd8;
    localparam logic [3:0] BRANCH = 4'd9;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    logic [3:0] state;
    logic [3:0] next_state;
    logic [3:0] st;         // state used for output decode
    logic [3:0] flags;      // {N, Z, C, V}
    logic       condex;
    logic       flagw;
    logic [3:0] cmd;
    logic       unused_rd;

    assign cmd       = funct[4:1];
    assign unused_rd = ^rd;
    assign state_o   = state;
    assign immsrc    = op;
    assign regsrc    = {op == 2'b01, op == 2'b10};

    // While reset is high the register may still hold anything before the
    // first edge; decode outputs from FETCH so the datapath sees FETCH selects.
    assign st = reset ? FETCH : state;

    // ARM condition evaluation against the stored flags
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags;
        condex = 1'b0;
        case (cond)
            4'b0000: condex = z;
            4'b0001: condex = ~z;
            4'b0010: condex = c;
            4'b0011: condex = ~c;
            4'b0100: condex = n;
            4'b0101: condex = ~n;
            4'b0110: condex = v;
            4'b0111: condex = ~v;
            4'b1000: condex = c & ~z;
            4'b1001: condex = ~c | z;
            4'b1010: condex = (n == v);
            4'b1011: condex = (n != v);
            4'b1100: condex = ~z & (n == v);
            4'b1101: condex = z | (n != v);
            default: condex = 1'b1;   // AL, and 1111 treated as AL
        endcase
    end

    // Next-state logic
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                if (!condex) begin
                    next_state = FETCH;
                end else begin
                    case (op)
                        2'b00:   next_state = funct[5] ? EXECI : EXECR;
                        2'b01:   next_state = MEMADR;
                        2'b10:   next_state = BRANCH;
                        default: next_state = FETCH;
                    endcase
                end
            end
            MEMADR: next_state = funct[0] ? MEMRD : MEMWR;
            MEMRD:  next_state = MEMWB;
            EXECR:  next_state = ALUWB;
            EXECI:  next_state = ALUWB;
            default: next_state = FETCH;
        endcase
    end

    // Output decode
    always_comb begin
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        adrsrc     = 1'b0;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        resultsrc  = 2'b00;
        alucontrol = 2'b00;
        flagw      = 1'b0;
`ifdef MULTICYCLE_CTRL_BL_EN
        linkwrite  = 1'b0;
`endif
        case (st)
            FETCH: begin
                alusrca   = 2'b01;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = 1'b1;
                pcwrite   = 1'b1;
            end
            DECODE: begin
                alusrca   = 2'b01;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
            end
            MEMADR: alusrcb = 2'b01;
            MEMRD:  adrsrc = 1'b1;
            MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
            end
            MEMWR: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
            end
            EXECR, EXECI: begin
                alusrcb = (st == EXECI) ? 2'b01 : 2'b00;
                case (cmd)
                    CMD_ADD: alucontrol = 2'b00;
                    CMD_SUB: alucontrol = 2'b01;
                    CMD_AND: alucontrol = 2'b10;
                    CMD_ORR: alucontrol = 2'b11;
                    CMD_CMP: alucontrol = 2'b01;
                    default: alucontrol = 2'b00;
                endcase
                flagw = funct[0] | (cmd == CMD_CMP);
            end
            ALUWB: regwrite = (cmd != CMD_CMP);
            BRANCH: begin
                alusrcb   = 2'b01;
                resultsrc = 2'b10;
                pcwrite   = 1'b1;
`ifdef MULTICYCLE_CTRL_BL_EN
                regwrite  = funct[4];
                linkwrite = funct[4];
`endif
            end
            default: ;
        endcase
        if (reset) begin
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
`ifdef MULTICYCLE_CTRL_BL_EN
            linkwrite = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            flags <= FLAGS_RESET;
        end else begin
            state <= next_state;
            if (flagw) begin
                flags[3:2] <= aluflags[3:2];
                // C and V are only meaningful for add/sub
                if (!alucontrol[1])
                    flags[1:0] <= aluflags[1:0];
            end
        end
    end

endmodule
